// File: rtl/arthas_mem_pkg.sv
// Shared types and default sizing for the memory-interface read path.
package arthas_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } rd_state_t;

    localparam int DEF_ADDR_W     = 28;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_MAX_OUT    = 4;
    localparam int DEF_RD_TIMEOUT = 1024;

endpackage

// File: rtl/rd_watchdog.sv
// Saturating 16-bit no-progress counter; expired holds once the limit-1 count is reached.
module rd_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT_M1 = 16'(LIMIT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT_M1)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign expired = (r_count == LIMIT_M1);

endmodule

// File: rtl/mif_rd.sv
// Read master: pops addresses from the input buffer controller, issues them to memory
// under a credit limit and forwards in-order responses one cycle later.
module mif_rd
    import arthas_mem_pkg::*;
#(
    parameter int rAddrWidth     = DEF_ADDR_W,
    parameter int rDataWidth     = DEF_DATA_W,
    parameter int maxOutstanding = DEF_MAX_OUT,
    parameter int rdTimeout      = DEF_RD_TIMEOUT
) (
    input  logic                                 clk_bus,
    input  logic                                 rst_bus,
    input  logic [rAddrWidth-1:0]                ibc2mem_r_addr,
    input  logic                                 ibc2mem_r_vld,
    output logic                                 mem2ibc_en,
    output logic [rDataWidth-1:0]                mem2ibc_data,
    output logic                                 mem2ibc_data_en,
    output logic [rAddrWidth-1:0]                mem_rd_addr,
    output logic                                 mem_rd_req,
    input  logic                                 mem_rd_gnt,
    input  logic [rDataWidth-1:0]                mem_rd_data,
    input  logic                                 mem_rd_data_vld,
    output logic                                 err_unexp,
    output logic                                 err_timeout,
    output logic [$clog2(maxOutstanding+1)-1:0]  outstanding
);

    localparam int OW = $clog2(maxOutstanding + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(maxOutstanding);

    rd_state_t               r_state;
    logic [rAddrWidth-1:0]   r_addr_q;
    logic [OW-1:0]           r_outstanding;
    logic [rDataWidth-1:0]   r_data;
    logic                    r_data_en;
    logic                    r_err_unexp;
    logic                    r_err_timeout;

    logic w_grant;
    logic w_rsp_ok;
    logic w_has_credit;
    logic w_wd_expired;

    assign w_grant      = (r_state == ISSUE) && mem_rd_gnt;
    assign w_rsp_ok     = mem_rd_data_vld && (r_outstanding != '0);
    assign w_has_credit = (r_outstanding < MAX_OUT);

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            r_state  <= IDLE;
            r_addr_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ibc2mem_r_vld && w_has_credit) r_state <= FETCH;
                end
                FETCH: begin
                    // vld can drop here when the buffer switches FIFOs; nothing was popped then
                    if (ibc2mem_r_vld) begin
                        r_addr_q <= ibc2mem_r_addr;
                        r_state  <= ISSUE;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                ISSUE: begin
                    if (mem_rd_gnt) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A grant and an accepted response in the same cycle cancel out
    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            r_outstanding <= '0;
        end else begin
            case ({w_grant, w_rsp_ok})
                2'b10: if (r_outstanding != MAX_OUT) r_outstanding <= r_outstanding + 1'b1;
                2'b01: r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            r_data        <= '0;
            r_data_en     <= 1'b0;
            r_err_unexp   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_data_en <= w_rsp_ok;
            if (w_rsp_ok) r_data <= mem_rd_data;
            if (mem_rd_data_vld && (r_outstanding == '0)) r_err_unexp <= 1'b1;
            if (w_wd_expired) r_err_timeout <= 1'b1;
        end
    end

    rd_watchdog #(
        .LIMIT (rdTimeout)
    ) u_watchdog (
        .clk     (clk_bus),
        .srst    (rst_bus),
        .clear   ((r_outstanding == '0) || mem_rd_data_vld),
        .enable  (r_outstanding != '0),
        .expired (w_wd_expired)
    );

    assign mem2ibc_en      = (r_state == FETCH) && ibc2mem_r_vld;
    assign mem_rd_req      = (r_state == ISSUE);
    assign mem_rd_addr     = r_addr_q;
    assign mem2ibc_data    = r_data;
    assign mem2ibc_data_en = r_data_en;
    assign err_unexp       = r_err_unexp;
    assign err_timeout     = r_err_timeout;
    assign outstanding     = r_outstanding;

endmodule

// File: tb/tb_mif_rd.sv
// Directed bench for mif_rd: reset, single read, credit limit, vld drop, held grant, errors.
module tb_mif_rd;

    logic        clk_bus = 1'b0;
    logic        rst_bus;
    logic [27:0] ibc2mem_r_addr;
    logic        ibc2mem_r_vld;
    logic        mem2ibc_en;
    logic [63:0] mem2ibc_data;
    logic        mem2ibc_data_en;
    logic [27:0] mem_rd_addr;
    logic        mem_rd_req;
    logic        mem_rd_gnt;
    logic [63:0] mem_rd_data;
    logic        mem_rd_data_vld;
    logic        err_unexp;
    logic        err_timeout;
    logic [2:0]  outstanding;

    int tests_run = 0;
    int tests_failed = 0;
    int pop_cnt = 0;
    int gnt_cnt = 0;

    mif_rd #(
        .rAddrWidth     (28),
        .rDataWidth     (64),
        .maxOutstanding (4),
        .rdTimeout      (16)
    ) dut (
        .clk_bus         (clk_bus),
        .rst_bus         (rst_bus),
        .ibc2mem_r_addr  (ibc2mem_r_addr),
        .ibc2mem_r_vld   (ibc2mem_r_vld),
        .mem2ibc_en      (mem2ibc_en),
        .mem2ibc_data    (mem2ibc_data),
        .mem2ibc_data_en (mem2ibc_data_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_req      (mem_rd_req),
        .mem_rd_gnt      (mem_rd_gnt),
        .mem_rd_data     (mem_rd_data),
        .mem_rd_data_vld (mem_rd_data_vld),
        .err_unexp       (err_unexp),
        .err_timeout     (err_timeout),
        .outstanding     (outstanding)
    );

    always #5 clk_bus = ~clk_bus;

    // Pops and grants are counted mid-cycle, when inputs and outputs are settled
    always @(negedge clk_bus) begin
        if (mem2ibc_en) pop_cnt++;
        if (mem_rd_req && mem_rd_gnt) gnt_cnt++;
    end

    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic do_reset();
        rst_bus = 1'b1; ibc2mem_r_vld = 1'b0; ibc2mem_r_addr = '0;
        mem_rd_gnt = 1'b0; mem_rd_data = '0; mem_rd_data_vld = 1'b0;
        tick(); tick();
        rst_bus = 1'b0;
    endtask

    task automatic test_reset();
        rst_bus = 1'b1; ibc2mem_r_vld = 1'b1; ibc2mem_r_addr = 28'h0FFFFFF;
        mem_rd_gnt = 1'b1; mem_rd_data = 64'h1; mem_rd_data_vld = 1'b1;
        tick(); tick(); tick();
        tests_run++; if (mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", mem_rd_req); end
        tests_run++; if (mem2ibc_en !== 1'b0) begin tests_failed++; $display("FAIL reset_pop: got %b expected 0", mem2ibc_en); end
        tests_run++; if (mem2ibc_data_en !== 1'b0) begin tests_failed++; $display("FAIL reset_data_en: got %b expected 0", mem2ibc_data_en); end
        tests_run++; if (mem2ibc_data !== 64'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", mem2ibc_data); end
        tests_run++; if (mem_rd_addr !== 28'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", mem_rd_addr); end
        tests_run++; if (outstanding !== 3'd0) begin tests_failed++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        tests_run++; if ({err_unexp, err_timeout} !== 2'b00) begin tests_failed++; $display("FAIL reset_errs: got %b expected 00", {err_unexp, err_timeout}); end
        $display("[TB] reset checked");
    endtask

    task automatic test_single_read();
        int p0;
        do_reset();
        p0 = pop_cnt;
        ibc2mem_r_vld = 1'b1; ibc2mem_r_addr = 28'h0000123; mem_rd_gnt = 1'b1;
        tick();
        tests_run++; if (mem2ibc_en !== 1'b1) begin tests_failed++; $display("FAIL single_pop: got %b expected 1", mem2ibc_en); end
        tick();
        ibc2mem_r_vld = 1'b0;
        tests_run++; if (mem_rd_req !== 1'b1) begin tests_failed++; $display("FAIL single_req: got %b expected 1", mem_rd_req); end
        tests_run++; if (mem_rd_addr !== 28'h0000123) begin tests_failed++; $display("FAIL single_addr: got %h expected 0000123", mem_rd_addr); end
        tick();
        tests_run++; if (outstanding !== 3'd1) begin tests_failed++; $display("FAIL single_outstanding: got %0d expected 1", outstanding); end
        tick(); tick(); tick(); tick();
        mem_rd_data_vld = 1'b1; mem_rd_data = 64'hDEADBEEF_00000001;
        tick();
        mem_rd_data_vld = 1'b0; mem_rd_data = 64'h0;
        tests_run++; if (mem2ibc_data_en !== 1'b1) begin tests_failed++; $display("FAIL single_data_en: got %b expected 1", mem2ibc_data_en); end
        tests_run++; if (mem2ibc_data !== 64'hDEADBEEF_00000001) begin tests_failed++; $display("FAIL single_data: got %h expected deadbeef00000001", mem2ibc_data); end
        tick();
        tests_run++; if (mem2ibc_data_en !== 1'b0) begin tests_failed++; $display("FAIL single_data_en_pulse: got %b expected 0", mem2ibc_data_en); end
        tests_run++; if (mem2ibc_data !== 64'hDEADBEEF_00000001) begin tests_failed++; $display("FAIL single_data_hold: got %h expected deadbeef00000001", mem2ibc_data); end
        tests_run++; if (outstanding !== 3'd0) begin tests_failed++; $display("FAIL single_outstanding_end: got %0d expected 0", outstanding); end
        tests_run++; if (pop_cnt - p0 !== 1) begin tests_failed++; $display("FAIL single_pop_count: got %0d expected 1", pop_cnt - p0); end
        $display("[TB] single read addr=0000123 data=%h", mem2ibc_data);
    endtask

    task automatic test_credit_limit();
        int p0, g0;
        do_reset();
        p0 = pop_cnt; g0 = gnt_cnt;
        ibc2mem_r_vld = 1'b1; ibc2mem_r_addr = 28'h0000400; mem_rd_gnt = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tests_run++; if (gnt_cnt - g0 !== 2) begin tests_failed++; $display("FAIL credit_throughput: got %0d grants expected 2", gnt_cnt - g0); end
        for (int i = 0; i < 13; i++) tick();
        tests_run++; if (pop_cnt - p0 !== 4) begin tests_failed++; $display("FAIL credit_pops: got %0d expected 4", pop_cnt - p0); end
        tests_run++; if (gnt_cnt - g0 !== 4) begin tests_failed++; $display("FAIL credit_grants: got %0d expected 4", gnt_cnt - g0); end
        tests_run++; if (outstanding !== 3'd4) begin tests_failed++; $display("FAIL credit_outstanding: got %0d expected 4", outstanding); end
        tests_run++; if (mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL credit_idle_req: got %b expected 0", mem_rd_req); end
        mem_rd_data_vld = 1'b1; mem_rd_data = 64'h0000_0000_CAFE_0004;
        tick();
        mem_rd_data_vld = 1'b0;
        tests_run++; if (mem2ibc_data_en !== 1'b1) begin tests_failed++; $display("FAIL credit_rsp_en: got %b expected 1", mem2ibc_data_en); end
        for (int i = 0; i < 4; i++) tick();
        tests_run++; if (pop_cnt - p0 !== 5) begin tests_failed++; $display("FAIL credit_fifth_pop: got %0d expected 5", pop_cnt - p0); end
        tests_run++; if (outstanding !== 3'd4) begin tests_failed++; $display("FAIL credit_refill: got %0d expected 4", outstanding); end
        ibc2mem_r_vld = 1'b0;
        $display("[TB] credit limit pops=%0d grants=%0d", pop_cnt - p0, gnt_cnt - g0);
    endtask

    task automatic test_vld_drop();
        int p0, g0;
        do_reset();
        p0 = pop_cnt; g0 = gnt_cnt;
        ibc2mem_r_vld = 1'b1; ibc2mem_r_addr = 28'h0000777; mem_rd_gnt = 1'b1;
        tick();
        ibc2mem_r_vld = 1'b0;
        #1;
        tests_run++; if (mem2ibc_en !== 1'b0) begin tests_failed++; $display("FAIL drop_pop: got %b expected 0", mem2ibc_en); end
        tick();
        tests_run++; if (mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL drop_req: got %b expected 0", mem_rd_req); end
        tick(); tick();
        tests_run++; if ((pop_cnt - p0) + (gnt_cnt - g0) !== 0) begin tests_failed++; $display("FAIL drop_activity: got %0d pops+grants expected 0", (pop_cnt - p0) + (gnt_cnt - g0)); end
        tests_run++; if (mem_rd_addr !== 28'h0) begin tests_failed++; $display("FAIL drop_addr: got %h expected 0", mem_rd_addr); end
        $display("[TB] vld drop in fetch");
    endtask

    task automatic test_held_request();
        int p0;
        do_reset();
        p0 = pop_cnt;
        ibc2mem_r_vld = 1'b1; ibc2mem_r_addr = 28'hABCDEF0; mem_rd_gnt = 1'b0;
        tick(); tick();
        ibc2mem_r_vld = 1'b0; ibc2mem_r_addr = 28'h1111111;
        for (int i = 0; i < 8; i++) begin
            tests_run++; if (mem_rd_req !== 1'b1) begin tests_failed++; $display("FAIL held_req[%0d]: got %b expected 1", i, mem_rd_req); end
            tests_run++; if (mem_rd_addr !== 28'hABCDEF0) begin tests_failed++; $display("FAIL held_addr[%0d]: got %h expected abcdef0", i, mem_rd_addr); end
            if (i == 7) mem_rd_gnt = 1'b1;
            tick();
        end
        mem_rd_gnt = 1'b0;
        tests_run++; if (mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL held_req_drop: got %b expected 0", mem_rd_req); end
        tests_run++; if (outstanding !== 3'd1) begin tests_failed++; $display("FAIL held_outstanding: got %0d expected 1", outstanding); end
        tests_run++; if (pop_cnt - p0 !== 1) begin tests_failed++; $display("FAIL held_pops: got %0d expected 1", pop_cnt - p0); end
        $display("[TB] held request addr=abcdef0");
    endtask

    task automatic test_errors();
        int g0;
        do_reset();
        mem_rd_data_vld = 1'b1; mem_rd_data = 64'h55;
        tick();
        mem_rd_data_vld = 1'b0;
        tests_run++; if (err_unexp !== 1'b1) begin tests_failed++; $display("FAIL unexp_flag: got %b expected 1", err_unexp); end
        tests_run++; if (mem2ibc_data_en !== 1'b0) begin tests_failed++; $display("FAIL unexp_dropped: got %b expected 0", mem2ibc_data_en); end
        tests_run++; if (outstanding !== 3'd0) begin tests_failed++; $display("FAIL unexp_no_wrap: got %0d expected 0", outstanding); end
        // response coinciding with the first grant
        do_reset();
        ibc2mem_r_vld = 1'b1; ibc2mem_r_addr = 28'h0000AAA; mem_rd_gnt = 1'b1;
        tick(); tick();
        ibc2mem_r_vld = 1'b0; mem_rd_data_vld = 1'b1; mem_rd_data = 64'h77;
        tick();
        mem_rd_data_vld = 1'b0; mem_rd_gnt = 1'b0;
        tests_run++; if (outstanding !== 3'd1) begin tests_failed++; $display("FAIL same_cycle_count: got %0d expected 1", outstanding); end
        tests_run++; if (mem2ibc_data_en !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_dropped: got %b expected 0", mem2ibc_data_en); end
        tests_run++; if (err_unexp !== 1'b1) begin tests_failed++; $display("FAIL same_cycle_unexp: got %b expected 1", err_unexp); end
        for (int i = 0; i < 14; i++) tick();
        tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_early: got %b expected 0", err_timeout); end
        tick(); tick();
        tests_run++; if (err_timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_flag: got %b expected 1", err_timeout); end
        g0 = gnt_cnt;
        ibc2mem_r_vld = 1'b1; mem_rd_gnt = 1'b1;
        tick(); tick(); tick();
        ibc2mem_r_vld = 1'b0;
        tests_run++; if (gnt_cnt - g0 !== 1) begin tests_failed++; $display("FAIL no_stall_grant: got %0d expected 1", gnt_cnt - g0); end
        tests_run++; if (outstanding !== 3'd2) begin tests_failed++; $display("FAIL no_stall_count: got %0d expected 2", outstanding); end
        tests_run++; if ({err_unexp, err_timeout} !== 2'b11) begin tests_failed++; $display("FAIL errs_sticky: got %b expected 11", {err_unexp, err_timeout}); end
        $display("[TB] error flags unexp=%b timeout=%b", err_unexp, err_timeout);
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        ibc2mem_r_vld = 1'b1; ibc2mem_r_addr = 28'h0000BBB; mem_rd_gnt = 1'b1;
        tick(); tick(); tick(); tick();
        mem_rd_gnt = 1'b0;
        tick();
        ibc2mem_r_vld = 1'b0;
        tests_run++; if ({mem_rd_req, outstanding} !== {1'b1, 3'd1}) begin tests_failed++; $display("FAIL mid_issue_setup: got req=%b out=%0d expected req=1 out=1", mem_rd_req, outstanding); end
        rst_bus = 1'b1;
        tick();
        tests_run++; if (mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL mid_issue_req_drop: got %b expected 0", mem_rd_req); end
        tests_run++; if (outstanding !== 3'd0) begin tests_failed++; $display("FAIL mid_issue_count: got %0d expected 0", outstanding); end
        rst_bus = 1'b0;
        mem_rd_data_vld = 1'b1; mem_rd_data = 64'h99;
        tick();
        mem_rd_data_vld = 1'b0;
        tests_run++; if (err_unexp !== 1'b1) begin tests_failed++; $display("FAIL stale_unexp: got %b expected 1", err_unexp); end
        tests_run++; if (mem2ibc_data_en !== 1'b0) begin tests_failed++; $display("FAIL stale_dropped: got %b expected 0", mem2ibc_data_en); end
        $display("[TB] reset mid-issue with stale response");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_credit_limit();
        test_vld_drop();
        test_held_request();
        test_errors();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
